alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 25 ++
 rtl/alu_arbiter_alu.sv | 48 ++++
 rtl/alu_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared FSM encodings, default width and ALU op codes
package alu_arbiter_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Arithmetic mode (l = 0)
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  // Logic mode (l = 1)
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU with arithmetic and logic modes
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int W = ALU_W
) (
  output logic [W-1:0] R,
  output logic         z,
  output logic         c,
  output logic         s,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         cin,
  input  logic [1:0]   Op,
  input  logic         l
);

  logic [W:0] cin_ext;
  logic [W:0] sum;

  assign cin_ext = {{W{1'b0}}, cin};

  // Logic mode leaves the top bit clear, so carry is always 0 there and cin is ignored.
  always_comb begin
    sum = '0;
    if (l) begin
      case (Op)
        OP_AND:  sum = {1'b0, A & B};
        OP_OR:   sum = {1'b0, A | B};
        OP_XOR:  sum = {1'b0, A ^ B};
        default: sum = {1'b0, ~A};
      endcase
    end else begin
      case (Op)
        OP_ADD:  sum = {1'b0, A} + {1'b0, B} + cin_ext;
        OP_SUB:  sum = {1'b0, A} + {1'b0, ~B} + cin_ext;
        OP_INC:  sum = {1'b0, A} + cin_ext;
        default: sum = {1'b0, A} + {1'b0, {W{1'b1}}} + cin_ext;
      endcase
    end
  end

  assign R = sum[W-1:0];
  assign c = sum[W];
  assign z = (sum[W-1:0] == '0);
  assign s = sum[W-1];

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic         l0,
  input  logic         l1,
  input  logic         cin0,
  input  logic         cin1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] res,
  output logic         z,
  output logic         c,
  output logic         s,
  output logic         rvalid,
  output logic         rid
);

  state_t       state;
  logic         last;
  logic         gnt_id;
  logic [1:0]   op_q;
  logic         l_q;
  logic         cin_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] alu_r;
  logic         alu_z;
  logic         alu_c;
  logic         alu_s;
  logic         win;
  logic         other_req;

  // On a tie the requester that did not win last time goes next.
  assign win       = (req0 && req1) ? ~last : req1;
  assign other_req = gnt_id ? req0 : req1;

  alu #(.W(W)) u_alu (
    .R   (alu_r),
    .z   (alu_z),
    .c   (alu_c),
    .s   (alu_s),
    .A   (a_q),
    .B   (b_q),
    .cin (cin_q),
    .Op  (op_q),
    .l   (l_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      last   <= 1'b1;
      gnt_id <= 1'b0;
      op_q   <= '0;
      l_q    <= 1'b0;
      cin_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res    <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      s      <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rvalid <= 1'b0;
      rid    <= 1'b0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            gnt_id <= win;
            last   <= win;
            state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          op_q  <= gnt_id ? op1  : op0;
          l_q   <= gnt_id ? l1   : l0;
          cin_q <= gnt_id ? cin1 : cin0;
          a_q   <= gnt_id ? a1   : a0;
          b_q   <= gnt_id ? b1   : b0;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          res    <= alu_r;
          z      <= alu_z;
          c      <= alu_c;
          s      <= alu_s;
          ack0   <= ~gnt_id;
          ack1   <= gnt_id;
          rvalid <= 1'b1;
          rid    <= gnt_id;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          // The served requester is still holding req here, so only the other one counts.
          if (other_req) begin
            gnt_id <= ~gnt_id;
            last   <= ~gnt_id;
            state  <= ST_GRANT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
